i2c_slave_seq: RTL

I2C_SLAVE_SEQ -- requirements
Module: i2c_slave_seq

---
 rtl/i2c_slave_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_seq.sv
// I2C slave fronting a byte-wide register file with a 16-bit auto-incrementing pointer.
// Write: DEVID, ADDR_MSB, ADDR_LSB, data...; read streams from the current pointer with a one-byte prefetch.
`timescale 1ns/1ps
module i2c_slave_seq #(
  parameter logic [6:0] DEV_ID = 7'h50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEVID, ACK_DEV, ADDR_MSB, ACK_MSB, ADDR_LSB, ACK_LSB,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_q, sda_q;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_reg;
  logic        rw_bit;
  logic        re_q;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte   = {rx_sr, sda_s};

  // NOTE: every register here uses <= so all updates see the pre-edge values
  // of their neighbours; a blocking '=' would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      sda_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_reg    <= '0;
      rw_bit    <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      re_q     <= mem_re;
      if (scl_rise) rx_sr <= rx_byte[6:0];
      // Read data lands one clk after the strobe; the pointer moves past it.
      if (re_q) tx_reg <= mem_rdata;
      if (re_q || mem_we) mem_addr <= mem_addr + 16'd1;

      if (start_det) begin
        state   <= DEVID;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          DEVID: if (scl_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ID) begin
                state  <= ACK_DEV;
                rw_bit <= rx_byte[0];
                mem_re <= rx_byte[0];
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_MSB: if (scl_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              mem_addr[15:8] <= rx_byte;
              state          <= ACK_MSB;
            end
          end
          ADDR_LSB: if (scl_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              mem_addr[7:0] <= rx_byte;
              state         <= ACK_LSB;
            end
          end
          WR_DATA: if (scl_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              mem_wdata <= rx_byte;
              mem_we    <= 1'b1;
              state     <= ACK_WR;
            end
          end
          // First fall pulls SDA for the ACK slot, second fall ends it.
          ACK_DEV, ACK_MSB, ACK_LSB, ACK_WR: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (state == ACK_DEV && rw_bit) begin
              sda_oe <= ~tx_reg[7];
              state  <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              if (state == ACK_DEV)      state <= ADDR_MSB;
              else if (state == ACK_MSB) state <= ADDR_LSB;
              else                       state <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              sda_oe <= ~tx_reg[~bit_cnt];
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RD_ACK;
            end
          end
          RD_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              if (!sda_s) begin
                mem_re <= 1'b1;
                state  <= RD_DATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          IDLE, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
